// File: rtl/stopwatch_core_if.sv
// stopwatch_core_if
//   Groups the stopwatch control inputs and display outputs into a single
//   interface bundle.
//   Signals:
//     CE10  - one-cycle 10 ms enable pulse
//     START - start/stop button level (debounced, synchronous)
//     CLEAR - clear button level (debounced, synchronous)
//     LAP   - lap button level (debounced, synchronous)
//     MIN   - displayed minutes, packed BCD
//     SEC   - displayed seconds, packed BCD
//     CSEC  - displayed centiseconds, packed BCD
//     RUN   - high while running
//     OVF   - sticky wrap flag
//     HOLD  - display frozen by a lap hold
//   Modports: master drives the buttons/enable, slave is the stopwatch core.
`timescale 1ns/1ps
interface stopwatch_core_if;
  logic       CE10;
  logic       START;
  logic       CLEAR;
  logic       LAP;
  logic [7:0] MIN;
  logic [7:0] SEC;
  logic [7:0] CSEC;
  logic       RUN;
  logic       OVF;
  logic       HOLD;

  modport master (
    output CE10, START, CLEAR, LAP,
    input  MIN, SEC, CSEC, RUN, OVF, HOLD
  );

  modport slave (
    input  CE10, START, CLEAR, LAP,
    output MIN, SEC, CSEC, RUN, OVF, HOLD
  );
endinterface

// File: rtl/stopwatch_core.sv
// stopwatch_core
//   Centisecond stopwatch driven by a 100 Hz clock enable. Keeps a BCD
//   MM:SS.CC count, with an IDLE/RUNNING/STOPPED state machine controlled
//   by edge-detected button levels. All outputs are registered.
//   Parameters:
//     MAXMIN - last minutes value before the count wraps to 00:00.00 (1..99)
//   Ports:
//     CLK - system clock
//     RST - asynchronous active-low reset
//     bus - stopwatch_core_if.slave (CE10/START/CLEAR/LAP in,
//           MIN/SEC/CSEC/RUN/OVF/HOLD out)
//   Optional feature macro: STOPWATCH_LAP_EN
//     Defined   : LAP pulses in RUNNING freeze/unfreeze the displayed value.
//     Undefined : LAP unused, HOLD tied 0, display equals the live count.
`timescale 1ns/1ps
module stopwatch_core #(
  parameter int unsigned MAXMIN = 59
) (
  input logic             CLK,
  input logic             RST,
  stopwatch_core_if.slave bus
);

  localparam logic [3:0] MM_T = 4'(MAXMIN / 10);
  localparam logic [3:0] MM_U = 4'(MAXMIN % 10);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUNNING,
    S_STOPPED
  } state_t;

  state_t r_state, w_state_nxt;

  logic r_start_q, r_clear_q, r_lap_q;
  logic w_start_p, w_clear_p, w_lap_p;
  logic w_tick, w_clr;

  logic [3:0] r_cs_u, r_cs_t, r_s_u, r_s_t, r_m_u, r_m_t;
  logic [3:0] w_cs_u, w_cs_t, w_s_u, w_s_t, w_m_u, w_m_t;
  logic       w_wrap;
  logic       r_ovf;

  // Button edge detection
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_start_q <= 1'b0;
      r_clear_q <= 1'b0;
      r_lap_q   <= 1'b0;
    end else begin
      r_start_q <= bus.START;
      r_clear_q <= bus.CLEAR;
      r_lap_q   <= bus.LAP;
    end
  end

  assign w_start_p = bus.START & ~r_start_q;
  assign w_clear_p = bus.CLEAR & ~r_clear_q;
  assign w_lap_p   = bus.LAP   & ~r_lap_q;

  // Counting depends on the pre-edge state only, so a START that stops the
  // watch still lets a coincident CE10 count, and one that starts it does not.
  assign w_tick = (r_state == S_RUNNING) && bus.CE10;

  // CLEAR only has an effect in STOPPED, where it outranks START.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_p) w_state_nxt = S_RUNNING;
      end
      S_RUNNING: begin
        if (w_start_p) w_state_nxt = S_STOPPED;
      end
      S_STOPPED: begin
        if (w_clear_p) begin
          w_state_nxt = S_IDLE;
          w_clr       = 1'b1;
        end else if (w_start_p) begin
          w_state_nxt = S_RUNNING;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Single-cycle BCD ripple: each digit advances only when all lower digits
  // roll over in this cycle.
  always_comb begin
    w_cs_u = r_cs_u;
    w_cs_t = r_cs_t;
    w_s_u  = r_s_u;
    w_s_t  = r_s_t;
    w_m_u  = r_m_u;
    w_m_t  = r_m_t;
    w_wrap = 1'b0;
    if (w_tick) begin
      if (r_cs_u != 4'd9) begin
        w_cs_u = r_cs_u + 4'd1;
      end else begin
        w_cs_u = '0;
        if (r_cs_t != 4'd9) begin
          w_cs_t = r_cs_t + 4'd1;
        end else begin
          w_cs_t = '0;
          if (r_s_u != 4'd9) begin
            w_s_u = r_s_u + 4'd1;
          end else begin
            w_s_u = '0;
            if (r_s_t != 4'd5) begin
              w_s_t = r_s_t + 4'd1;
            end else begin
              w_s_t = '0;
              if (r_m_t == MM_T && r_m_u == MM_U) begin
                w_m_t  = '0;
                w_m_u  = '0;
                w_wrap = 1'b1;
              end else if (r_m_u != 4'd9) begin
                w_m_u = r_m_u + 4'd1;
              end else begin
                w_m_u = '0;
                w_m_t = r_m_t + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cs_u <= '0;
      r_cs_t <= '0;
      r_s_u  <= '0;
      r_s_t  <= '0;
      r_m_u  <= '0;
      r_m_t  <= '0;
      r_ovf  <= 1'b0;
    end else if (w_clr) begin
      r_cs_u <= '0;
      r_cs_t <= '0;
      r_s_u  <= '0;
      r_s_t  <= '0;
      r_m_u  <= '0;
      r_m_t  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_cs_u <= w_cs_u;
      r_cs_t <= w_cs_t;
      r_s_u  <= w_s_u;
      r_s_t  <= w_s_t;
      r_m_u  <= w_m_u;
      r_m_t  <= w_m_t;
      if (w_wrap) r_ovf <= 1'b1;
    end
  end

  assign bus.RUN = (r_state == S_RUNNING);
  assign bus.OVF = r_ovf;

`ifdef STOPWATCH_LAP_EN
  logic       r_hold;
  logic [7:0] r_d_min, r_d_sec, r_d_csec;
  logic       w_lap_act;

  // START outranks LAP, so a coincident stop press suppresses the lap.
  assign w_lap_act = (r_state == S_RUNNING) && w_lap_p && !w_start_p;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hold   <= 1'b0;
      r_d_min  <= '0;
      r_d_sec  <= '0;
      r_d_csec <= '0;
    end else if (w_clr) begin
      r_hold <= 1'b0;
    end else if (w_lap_act) begin
      if (!r_hold) begin
        r_hold   <= 1'b1;
        r_d_min  <= {r_m_t, r_m_u};
        r_d_sec  <= {r_s_t, r_s_u};
        r_d_csec <= {r_cs_t, r_cs_u};
      end else begin
        r_hold <= 1'b0;
      end
    end
  end

  assign bus.HOLD = r_hold;
  assign bus.MIN  = r_hold ? r_d_min  : {r_m_t, r_m_u};
  assign bus.SEC  = r_hold ? r_d_sec  : {r_s_t, r_s_u};
  assign bus.CSEC = r_hold ? r_d_csec : {r_cs_t, r_cs_u};
`else
  logic w_unused_lap;
  assign w_unused_lap = w_lap_p;

  assign bus.HOLD = 1'b0;
  assign bus.MIN  = {r_m_t, r_m_u};
  assign bus.SEC  = {r_s_t, r_s_u};
  assign bus.CSEC = {r_cs_t, r_cs_u};
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core
//   Self-checking bench for stopwatch_core. A behavioural model keeps the
//   count as an integer number of centiseconds and converts it to BCD;
//   expected outputs are queued when stimulus is driven and compared one
//   cycle later. A short table of hand-derived vectors covers the basic
//   edge/priority behaviour, followed by longer scripted sequences.
//   MAXMIN is overridden to 1 so the minute wrap is reachable quickly.
`timescale 1ns/1ps
module tb_stopwatch_core;

  localparam int unsigned MAXMIN_TB = 1;
  localparam int          LIMIT     = (MAXMIN_TB + 1) * 6000;

  logic CLK = 1'b0;
  logic RST;

  stopwatch_core_if bus ();

  stopwatch_core #(.MAXMIN(MAXMIN_TB)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] csec;
    logic       run;
    logic       ovf;
    logic       hold;
  } exp_t;

  typedef struct {
    bit   ce;
    bit   st;
    bit   cl;
    bit   lp;
    exp_t exp;
  } vec_t;

  exp_t  sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  string tag   = "init";

  // Model state: 0 = IDLE, 1 = RUNNING, 2 = STOPPED
  int m_state;
  int m_cnt;
  int m_disp;
  bit m_ovf, m_hold, m_pst, m_pcl, m_plp;

  function automatic logic [7:0] bcd2(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic exp_t mk(input logic [7:0] mi, input logic [7:0] se,
                              input logic [7:0] cs, input bit run,
                              input bit ovf, input bit hold);
    exp_t e;
    e.min  = mi;
    e.sec  = se;
    e.csec = cs;
    e.run  = run;
    e.ovf  = ovf;
    e.hold = hold;
    return e;
  endfunction

  function automatic exp_t model_out();
    int d;
    d = m_hold ? m_disp : m_cnt;
    return mk(bcd2(d / 6000), bcd2((d / 100) % 60), bcd2(d % 100),
              (m_state == 1), m_ovf, m_hold);
  endfunction

  function automatic exp_t dut_out();
    return mk(bus.MIN, bus.SEC, bus.CSEC, bus.RUN, bus.OVF, bus.HOLD);
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_disp  = 0;
    m_ovf   = 1'b0;
    m_hold  = 1'b0;
    m_pst   = 1'b0;
    m_pcl   = 1'b0;
    m_plp   = 1'b0;
  endtask

  task automatic model_edge(input bit ce, input bit st, input bit cl, input bit lp);
    bit sp, cp, lpp, tick, clr;
    int ns;
    sp   = st && !m_pst;
    cp   = cl && !m_pcl;
    lpp  = lp && !m_plp;
    tick = (m_state == 1) && ce;
    clr  = (m_state == 2) && cp;
    ns   = m_state;
    case (m_state)
      0: if (sp) ns = 1;
      1: if (sp) ns = 2;
      default: begin
        if (cp)      ns = 0;
        else if (sp) ns = 1;
      end
    endcase
`ifdef STOPWATCH_LAP_EN
    if (m_state == 1 && lpp && !sp) begin
      if (!m_hold) begin
        m_disp = m_cnt;
        m_hold = 1'b1;
      end else begin
        m_hold = 1'b0;
      end
    end
`else
    if (lpp) m_hold = 1'b0;
`endif
    if (clr) begin
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_hold = 1'b0;
    end else if (tick) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == LIMIT) begin
        m_cnt = 0;
        m_ovf = 1'b1;
      end
    end
    m_state = ns;
    m_pst   = st;
    m_pcl   = cl;
    m_plp   = lp;
  endtask

  task automatic compare(input exp_t e);
    exp_t g;
    g = dut_out();
    n_vec++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s: got MIN=%h SEC=%h CSEC=%h RUN=%b OVF=%b HOLD=%b, required MIN=%h SEC=%h CSEC=%h RUN=%b OVF=%b HOLD=%b",
               tag, g.min, g.sec, g.csec, g.run, g.ovf, g.hold,
               e.min, e.sec, e.csec, e.run, e.ovf, e.hold);
    end
  endtask

  task automatic check_pop();
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got nothing to compare, required one entry", tag);
    end else begin
      compare(sb_q.pop_front());
    end
  endtask

  task automatic chk(input string t, input exp_t e);
    tag = t;
    compare(e);
  endtask

  task automatic drive(input bit ce, input bit st, input bit cl, input bit lp);
    bus.CE10  = ce;
    bus.START = st;
    bus.CLEAR = cl;
    bus.LAP   = lp;
  endtask

  task automatic step(input bit ce, input bit st, input bit cl, input bit lp);
    drive(ce, st, cl, lp);
    model_edge(ce, st, cl, lp);
    sb_q.push_back(model_out());
    @(posedge CLK);
    #1;
    check_pop();
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int j = 1; j < gap; j++) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  vec_t tab[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z;
    z = mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    tab[0]  = '{1, 0, 0, 0, mk(8'h00, 8'h00, 8'h00, 0, 0, 0)};  // CE10 in IDLE ignored
    tab[1]  = '{1, 1, 0, 0, mk(8'h00, 8'h00, 8'h00, 1, 0, 0)};  // start, CE10 not counted
    tab[2]  = '{1, 1, 0, 0, mk(8'h00, 8'h00, 8'h01, 1, 0, 0)};  // held START, tick
    tab[3]  = '{0, 0, 0, 0, mk(8'h00, 8'h00, 8'h01, 1, 0, 0)};
    tab[4]  = '{1, 0, 0, 0, mk(8'h00, 8'h00, 8'h02, 1, 0, 0)};
    tab[5]  = '{1, 0, 1, 0, mk(8'h00, 8'h00, 8'h03, 1, 0, 0)};  // CLEAR ignored in RUNNING
    tab[6]  = '{1, 1, 0, 0, mk(8'h00, 8'h00, 8'h04, 0, 0, 0)};  // stop, CE10 counts
    tab[7]  = '{1, 0, 0, 0, mk(8'h00, 8'h00, 8'h04, 0, 0, 0)};  // CE10 in STOPPED ignored
    tab[8]  = '{1, 1, 0, 0, mk(8'h00, 8'h00, 8'h04, 1, 0, 0)};  // resume, CE10 not counted
    tab[9]  = '{1, 0, 0, 0, mk(8'h00, 8'h00, 8'h05, 1, 0, 0)};
    tab[10] = '{0, 1, 0, 0, mk(8'h00, 8'h00, 8'h05, 0, 0, 0)};
    tab[11] = '{0, 0, 1, 0, mk(8'h00, 8'h00, 8'h00, 0, 0, 0)};  // clear from STOPPED
    tab[12] = '{1, 0, 0, 0, mk(8'h00, 8'h00, 8'h00, 0, 0, 0)};

    RST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #12;
    chk("reset", z);
    RST = 1'b1;

    for (int i = 0; i < 13; i++) begin
      tag = $sformatf("table[%0d]", i);
      drive(tab[i].ce, tab[i].st, tab[i].cl, tab[i].lp);
      model_edge(tab[i].ce, tab[i].st, tab[i].cl, tab[i].lp);
      sb_q.push_back(tab[i].exp);
      @(posedge CLK);
      #1;
      check_pop();
    end

    // 150 ticks, one every 4 clocks
    tag = "run150";
    step(0, 1, 0, 0);
    ticks(150, 4);
    chk("run150_end", mk(8'h00, 8'h01, 8'h50, 1, 0, 0));

    // START held for 20 cycles gives one transition
    tag = "start_held";
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0);
    chk("start_held_end", mk(8'h00, 8'h00, 8'h19, 1, 0, 0));
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    ticks(10, 1);
    chk("stopped_frozen", mk(8'h00, 8'h00, 8'h20, 0, 0, 0));

    // Carry chain and wrap
    tag = "carry";
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    ticks(5999, 1);
    chk("at_00_59_99", mk(8'h00, 8'h59, 8'h99, 1, 0, 0));
    ticks(1, 1);
    chk("at_01_00_00", mk(8'h01, 8'h00, 8'h00, 1, 0, 0));
    ticks(5999, 1);
    chk("at_max", mk(8'h01, 8'h59, 8'h99, 1, 0, 0));
    ticks(1, 1);
    chk("wrap", mk(8'h00, 8'h00, 8'h00, 1, 1, 0));
    ticks(7, 1);
    chk("after_wrap", mk(8'h00, 8'h00, 8'h07, 1, 1, 0));
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("clear_ovf", z);
    step(0, 0, 0, 0);

    // START and CLEAR together in STOPPED
    tag = "start_clear";
    step(0, 1, 0, 0);
    ticks(3, 1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    chk("start_clear_end", z);
    step(0, 0, 0, 0);

    // Lap hold
    tag = "lap";
    step(0, 1, 0, 0);
    ticks(237, 1);
    step(0, 0, 0, 1);
`ifdef STOPWATCH_LAP_EN
    chk("lap_first", mk(8'h00, 8'h02, 8'h37, 1, 0, 1));
    ticks(100, 1);
    chk("lap_held", mk(8'h00, 8'h02, 8'h37, 1, 0, 1));
    step(0, 0, 0, 1);
    chk("lap_release", mk(8'h00, 8'h03, 8'h37, 1, 0, 0));
`else
    chk("lap_first", mk(8'h00, 8'h02, 8'h37, 1, 0, 0));
    ticks(100, 1);
    chk("lap_ignored", mk(8'h00, 8'h03, 8'h37, 1, 0, 0));
    step(0, 0, 0, 1);
`endif
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Asynchronous reset mid-count
    tag = "async_rst";
    step(0, 1, 0, 0);
    ticks(1234, 1);
    chk("at_00_12_34", mk(8'h00, 8'h12, 8'h34, 1, 0, 0));
    #2;
    RST = 1'b0;
    model_reset();
    #1;
    chk("async_rst_now", z);
    @(negedge CLK);
    RST = 1'b1;
    tag = "post_rst";
    ticks(5, 1);
    chk("post_rst_idle", z);
    step(0, 1, 0, 0);
    ticks(3, 1);
    chk("post_rst_run", mk(8'h00, 8'h00, 8'h03, 1, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
